// File: rtl/vt52_screen_writer.sv
// VT52 screen writer: parses a byte stream with VT52 control codes, writes characters into
// the 80x24 screen RAM and maintains the cursor and hardware-scroll top line.
module vt52_screen_writer #(
  parameter logic [6:0] FILL_CHAR  = 7'h20,
  parameter bit         CLR_ON_RST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] screenmem_addr,
  output logic [6:0]  screenmem_data,
  output logic        screenmem_we,
  output logic [6:0]  curX,
  output logic [4:0]  curY,
  output logic [4:0]  topline
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC,
    S_ESCY_ROW,
    S_ESCY_COL,
    S_CLEAR
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  cur_x_reg, cur_x_next;
  logic [4:0]  cur_y_reg, cur_y_next;
  logic [4:0]  top_reg, top_next;
  logic [6:0]  row_arg_reg, row_arg_next;
  logic        wr_pend_reg, wr_pend_next;
  logic [10:0] wr_addr_reg, wr_addr_next;
  logic [6:0]  wr_data_reg, wr_data_next;
  logic [6:0]  clr_x_reg, clr_x_next;
  logic [4:0]  clr_y_reg, clr_y_next;
  logic [4:0]  clr_rows_reg, clr_rows_next;

  logic        ready_int;
  logic        xfer;
  logic [6:0]  b;
  logic [6:0]  arg;
  logic [6:0]  tab_stop;
  logic [5:0]  lrow_wide;
  logic [5:0]  lrow_sub;
  logic [4:0]  lrow;
  logic        unused_bit7;

  // VT52 address map: columns 64..79 are folded into the otherwise unused upper region.
  function automatic logic [10:0] map_addr(input logic [6:0] x, input logic [4:0] y);
    if (x[6] || (y[4] && y[3]))
      map_addr = {y[0], 2'b11, y[2:1], y[4:3], x[3:0]};
    else
      map_addr = {y[0], y[4:1], x[5:0]};
  endfunction

  function automatic logic [4:0] row_inc(input logic [4:0] y);
    row_inc = (y == 5'd23) ? 5'd0 : y + 5'd1;
  endfunction

  function automatic logic [4:0] row_dec(input logic [4:0] y);
    row_dec = (y == 5'd0) ? 5'd23 : y - 5'd1;
  endfunction

  function automatic logic [4:0] row_add(input logic [4:0] a, input logic [4:0] c);
    logic [5:0] s;
    logic [5:0] d;
    s = {1'b0, a} + {1'b0, c};
    d = s - 6'd24;
    row_add = (s >= 6'd24) ? d[4:0] : s[4:0];
  endfunction

  assign unused_bit7 = char_data[7];
  assign b           = char_data[6:0];
  assign arg         = b - 7'd32;
  assign tab_stop    = (cur_x_reg | 7'd7) + 7'd1;

  // Logical row of the cursor relative to the scrolled top line.
  assign lrow_wide = {1'b0, cur_y_reg} + 6'd24 - {1'b0, top_reg};
  assign lrow_sub  = lrow_wide - 6'd24;
  assign lrow      = (lrow_wide >= 6'd24) ? lrow_sub[4:0] : lrow_wide[4:0];

  assign ready_int = (state_reg != S_CLEAR) && !reset;
  assign xfer      = char_valid && ready_int;

  always_comb begin
    state_next    = state_reg;
    cur_x_next    = cur_x_reg;
    cur_y_next    = cur_y_reg;
    top_next      = top_reg;
    row_arg_next  = row_arg_reg;
    wr_pend_next  = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    clr_x_next    = clr_x_reg;
    clr_y_next    = clr_y_reg;
    clr_rows_next = clr_rows_reg;

    case (state_reg)
      S_IDLE: begin
        if (xfer) begin
          if (b >= 7'h20 && b <= 7'h7e) begin
            wr_pend_next = 1'b1;
            wr_addr_next = map_addr(cur_x_reg, cur_y_reg);
            wr_data_next = b;
            if (cur_x_reg != 7'd79) cur_x_next = cur_x_reg + 7'd1;
          end else begin
            case (b)
              7'h0d: cur_x_next = 7'd0;
              7'h08: if (cur_x_reg != 7'd0) cur_x_next = cur_x_reg - 7'd1;
              7'h09: cur_x_next = (tab_stop > 7'd79) ? 7'd79 : tab_stop;
              7'h0a: begin
                if (lrow != 5'd23) begin
                  cur_y_next = row_inc(cur_y_reg);
                end else begin
                  // Bottom line: scroll by advancing topline and blank the recycled row.
                  top_next      = row_inc(top_reg);
                  cur_y_next    = top_reg;
                  clr_x_next    = 7'd0;
                  clr_y_next    = top_reg;
                  clr_rows_next = 5'd0;
                  state_next    = S_CLEAR;
                end
              end
              7'h1b: state_next = S_ESC;
              default: ;
            endcase
          end
        end
      end

      S_ESC: begin
        if (xfer) begin
          state_next = S_IDLE;
          case (b)
            7'h41: if (lrow != 5'd0) cur_y_next = row_dec(cur_y_reg);
            7'h42: if (lrow != 5'd23) cur_y_next = row_inc(cur_y_reg);
            7'h43: if (cur_x_reg != 7'd79) cur_x_next = cur_x_reg + 7'd1;
            7'h44: if (cur_x_reg != 7'd0) cur_x_next = cur_x_reg - 7'd1;
            7'h48: begin
              cur_x_next = 7'd0;
              cur_y_next = top_reg;
            end
            7'h4a: begin
              clr_x_next    = cur_x_reg;
              clr_y_next    = cur_y_reg;
              clr_rows_next = 5'd23 - lrow;
              state_next    = S_CLEAR;
            end
            7'h4b: begin
              clr_x_next    = cur_x_reg;
              clr_y_next    = cur_y_reg;
              clr_rows_next = 5'd0;
              state_next    = S_CLEAR;
            end
            7'h59: state_next = S_ESCY_ROW;
            default: ;
          endcase
        end
      end

      S_ESCY_ROW: begin
        if (xfer) begin
          row_arg_next = arg;
          state_next   = S_ESCY_COL;
        end
      end

      S_ESCY_COL: begin
        if (xfer) begin
          // Out-of-range coordinates (including bytes below 0x20, which wrap high) are ignored.
          if (row_arg_reg <= 7'd23) cur_y_next = row_add(top_reg, row_arg_reg[4:0]);
          if (arg <= 7'd79) cur_x_next = arg;
          state_next = S_IDLE;
        end
      end

      S_CLEAR: begin
        if (clr_x_reg == 7'd79) begin
          if (clr_rows_reg == 5'd0) begin
            state_next = S_IDLE;
          end else begin
            clr_x_next    = 7'd0;
            clr_y_next    = row_inc(clr_y_reg);
            clr_rows_next = clr_rows_reg - 5'd1;
          end
        end else begin
          clr_x_next = clr_x_reg + 7'd1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= CLR_ON_RST ? S_CLEAR : S_IDLE;
      cur_x_reg    <= 7'd0;
      cur_y_reg    <= 5'd0;
      top_reg      <= 5'd0;
      row_arg_reg  <= 7'd0;
      wr_pend_reg  <= 1'b0;
      wr_addr_reg  <= 11'd0;
      wr_data_reg  <= 7'd0;
      clr_x_reg    <= 7'd0;
      clr_y_reg    <= 5'd0;
      clr_rows_reg <= 5'd23;
    end else begin
      state_reg    <= state_next;
      cur_x_reg    <= cur_x_next;
      cur_y_reg    <= cur_y_next;
      top_reg      <= top_next;
      row_arg_reg  <= row_arg_next;
      wr_pend_reg  <= wr_pend_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      clr_x_reg    <= clr_x_next;
      clr_y_reg    <= clr_y_next;
      clr_rows_reg <= clr_rows_next;
    end
  end

  // Clear writes come straight from the clear counters; character writes are registered.
  assign char_ready     = ready_int;
  assign screenmem_we   = !reset && ((state_reg == S_CLEAR) || wr_pend_reg);
  assign screenmem_addr = (state_reg == S_CLEAR) ? map_addr(clr_x_reg, clr_y_reg) : wr_addr_reg;
  assign screenmem_data = (state_reg == S_CLEAR) ? FILL_CHAR : wr_data_reg;
  assign curX           = cur_x_reg;
  assign curY           = cur_y_reg;
  assign topline        = top_reg;

endmodule
